scratchpad_arbiter: RTL
=======================

Name: scratchpad_arbiter

Overview:
- Shares one scratchpad instance (1 combinational read port, 1 registered write port, CS) between NUM_REQ requesters, e.g. aggregation lanes and the feature loader.
- Two independent round-robin arbiters, one for the read port and one for the write port. Each has a per-requester lock for bursts.
- Registers read data back to the winning requester with a one-hot valid.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, element width in bits
- PARALLELISM, 1, elements per scratchpad row
- HEIGHT, 128, scratchpad rows; AW = $clog2(HEIGHT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  NUM_REQ  per-requester read request
- rd_lock  in  NUM_REQ  keep read grant while asserted with rd_req
- rd_addr  in  NUM_REQ*AW  packed read addresses, requester i at [i*AW +: AW]
- rd_gnt  out  NUM_REQ  one-hot read grant, combinational
- rd_data  out  PARALLELISM*WIDTH  registered read data, shared bus
- rd_valid  out  NUM_REQ  one-hot, marks owner of rd_data
- wr_req  in  NUM_REQ  per-requester write request
- wr_lock  in  NUM_REQ  keep write grant while asserted with wr_req
- wr_addr  in  NUM_REQ*AW  packed write addresses
- wr_data  in  NUM_REQ*PARALLELISM*WIDTH  packed write data
- wr_gnt  out  NUM_REQ  one-hot write grant, combinational
- spad_cs  out  1  scratchpad CS
- spad_read_en / spad_read_addr  out  1 / AW  to scratchpad read port
- spad_qout  in  PARALLELISM*WIDTH  scratchpad read data (0-cycle)
- spad_write_en / spad_write_addr / spad_din  out  1 / AW / PARALLELISM*WIDTH  to scratchpad write port

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on posedge clk.
- Reset values:
  - rd_valid=0, rd_data=0.
  - rd_ptr = wr_ptr = NUM_REQ-1, so requester 0 wins first.
  - rd_owner_locked = wr_owner_locked = 0.
  - While rst=1: all grants and spad enables forced to 0.
- Read arbitration, per cycle:
  - If rd_owner_locked and rd_req[rd_ptr] is set: grant rd_ptr.
  - Else grant the first requester with rd_req set, searching rd_ptr+1, rd_ptr+2, … modulo NUM_REQ (wrap from NUM_REQ-1 to 0).
  - No request: rd_gnt=0.
- On a read grant to g:
  - Drive spad_read_en=1, spad_read_addr=rd_addr[g].
  - Next cycle: rd_data=spad_qout and rd_valid=onehot(g). Read latency is exactly 1 cycle from grant.
  - rd_ptr<=g; rd_owner_locked<=rd_lock[g].
- No read grant: rd_valid<=0, rd_data holds, rd_ptr holds, rd_owner_locked<=0.
- Lock release: dropping rd_req or rd_lock releases ownership. Arbitration resumes from g+1 in the following cycle.
- Write arbitration: identical algorithm with wr_ptr / wr_owner_locked. Grant g drives spad_write_en=1, spad_write_addr=wr_addr[g], spad_din=wr_data[g]. The write lands at the clock edge. The requester treats the write as done when wr_gnt[g]=1.
- Read and write grants are independent; both may be granted in the same cycle, to the same or different requesters.
- spad_cs = any read grant or any write grant.
- Same-cycle read and write to the same address: read returns OLD data (scratchpad write is registered), unless forwarding is enabled (see Optional Feature).
- Requests are level signals. A requester holds addr/data stable until it sees its gnt bit. A requester that is not granted simply retries next cycle.
- Fairness: with all NUM_REQ requesting and no locks, each is granted exactly once every NUM_REQ cycles.
- Reset mid-burst: locks are cleared, pointers reset, and an in-flight rd_valid is dropped the next cycle.

Optional Feature:
- Macro SPAD_ARB_FWD_EN.
- Defined: if read and write are granted in the same cycle with spad_read_addr == spad_write_addr, rd_data next cycle = spad_din (new data) instead of spad_qout.
- Undefined: rd_data always = spad_qout (old data); no address comparator is instantiated.

Test Plan:
- Reset then single requester: rd_req=4'b0001, rd_addr[0]=5; row 5 preloaded 0x3C -> rd_gnt=0001 same cycle; next cycle rd_valid=0001, rd_data=0x3C.
- Round-robin fairness: rd_req=4'b1111 held 8 cycles, no locks -> grant sequence 0,1,2,3,0,1,2,3; rd_valid follows one cycle later.
- Lock burst: req 2 asserts rd_req and rd_lock for 4 cycles while reqs 0 and 3 also request -> 4 consecutive grants to 2. After lock drop, next grant is 3, then 0.
- Write arbitration with wrap: wr_req=4'b1001 after last write grant to 3 -> grant 0, then 3; scratchpad rows at wr_addr hold the respective wr_data.
- Same-address collision: write 0xAA to row 7 (old value 0x11) and read row 7 in the same cycle -> rd_data=0x11 without SPAD_ARB_FWD_EN, 0xAA with it. Read of row 7 the following cycle returns 0xAA in both builds.
- Reset mid-burst: rst during a locked read burst from req 1 -> rd_gnt=0 and spad_cs=0 during reset; rd_valid=0 the cycle after. First post-reset grant with rd_req=4'b1110 goes to requester 1.

Source files
------------

// File: rtl/scratchpad_arbiter_if.sv
// Requester-side and scratchpad-side signals for scratchpad_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the scratchpad.
interface scratchpad_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int PARALLELISM = 1,
    parameter int HEIGHT      = 128
);
    localparam int AW = $clog2(HEIGHT);
    localparam int DW = PARALLELISM * WIDTH;

    logic [NUM_REQ-1:0]    rd_req;
    logic [NUM_REQ-1:0]    rd_lock;
    logic [NUM_REQ*AW-1:0] rd_addr;
    logic [NUM_REQ-1:0]    rd_gnt;
    logic [DW-1:0]         rd_data;
    logic [NUM_REQ-1:0]    rd_valid;

    logic [NUM_REQ-1:0]    wr_req;
    logic [NUM_REQ-1:0]    wr_lock;
    logic [NUM_REQ*AW-1:0] wr_addr;
    logic [NUM_REQ*DW-1:0] wr_data;
    logic [NUM_REQ-1:0]    wr_gnt;

    logic                  spad_cs;
    logic                  spad_read_en;
    logic [AW-1:0]         spad_read_addr;
    logic [DW-1:0]         spad_qout;
    logic                  spad_write_en;
    logic [AW-1:0]         spad_write_addr;
    logic [DW-1:0]         spad_din;

    modport slave (
        input  rd_req, rd_lock, rd_addr, wr_req, wr_lock, wr_addr, wr_data, spad_qout,
        output rd_gnt, rd_data, rd_valid, wr_gnt, spad_cs, spad_read_en, spad_read_addr,
               spad_write_en, spad_write_addr, spad_din
    );

    modport master (
        output rd_req, rd_lock, rd_addr, wr_req, wr_lock, wr_addr, wr_data, spad_qout,
        input  rd_gnt, rd_data, rd_valid, wr_gnt, spad_cs, spad_read_en, spad_read_addr,
               spad_write_en, spad_write_addr, spad_din
    );
endinterface

// File: rtl/scratchpad_arbiter.sv
// Round-robin read/write port arbiter (with per-requester burst lock) in front of one scratchpad.
// Define SPAD_ARB_FWD_EN to forward same-cycle same-address write data onto the read return.
module scratchpad_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int PARALLELISM = 1,
    parameter int HEIGHT      = 128
) (
    input logic               clk,
    input logic               rst,
    scratchpad_arbiter_if.slave bus
);
    localparam int AW = $clog2(HEIGHT);
    localparam int DW = PARALLELISM * WIDTH;
    localparam int IW = $clog2(NUM_REQ);

    // Returns {found, index}; a locked owner that still requests keeps the grant.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0]      ptr,
                                            input logic               locked);
        logic [IW:0] pick;
        int          idx;
        pick = '0;
        if (locked && req[ptr]) begin
            pick = {1'b1, ptr};
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = (int'(ptr) + i) % NUM_REQ;
                if (!pick[IW] && req[IW'(idx)]) pick = {1'b1, IW'(idx)};
            end
        end
        return pick;
    endfunction

    logic [IW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic               rd_locked_q, rd_locked_d, wr_locked_q, wr_locked_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [DW-1:0]      rd_data_q, rd_data_d;

    logic [IW:0]        rd_pick, wr_pick;
    logic               rd_hit, wr_hit;
    logic [IW-1:0]      rd_idx, wr_idx;
    logic [DW-1:0]      rd_qin;

    always_comb begin
        rd_pick = rr_pick(bus.rd_req, rd_ptr_q, rd_locked_q);
        wr_pick = rr_pick(bus.wr_req, wr_ptr_q, wr_locked_q);
        rd_hit  = rd_pick[IW] && !rst;
        wr_hit  = wr_pick[IW] && !rst;
        rd_idx  = rd_pick[IW-1:0];
        wr_idx  = wr_pick[IW-1:0];

        bus.rd_gnt = '0;
        bus.wr_gnt = '0;
        if (rd_hit) bus.rd_gnt[rd_idx] = 1'b1;
        if (wr_hit) bus.wr_gnt[wr_idx] = 1'b1;

        bus.spad_read_en    = rd_hit;
        bus.spad_read_addr  = bus.rd_addr[rd_idx*AW +: AW];
        bus.spad_write_en   = wr_hit;
        bus.spad_write_addr = bus.wr_addr[wr_idx*AW +: AW];
        bus.spad_din        = bus.wr_data[wr_idx*DW +: DW];
        bus.spad_cs         = rd_hit | wr_hit;
    end

`ifdef SPAD_ARB_FWD_EN
    // The scratchpad write is registered, so a same-address read would otherwise see stale data.
    always_comb begin
        rd_qin = bus.spad_qout;
        if (rd_hit && wr_hit && (bus.spad_read_addr == bus.spad_write_addr)) rd_qin = bus.spad_din;
    end
`else
    always_comb begin
        rd_qin = bus.spad_qout;
    end
`endif

    always_comb begin
        rd_valid_d  = bus.rd_gnt;
        rd_data_d   = rd_hit ? rd_qin : rd_data_q;
        rd_ptr_d    = rd_hit ? rd_idx : rd_ptr_q;
        rd_locked_d = rd_hit && bus.rd_lock[rd_idx];
        wr_ptr_d    = wr_hit ? wr_idx : wr_ptr_q;
        wr_locked_d = wr_hit && bus.wr_lock[wr_idx];
    end

    // Pointers reset to the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= IW'(NUM_REQ - 1);
            wr_ptr_q    <= IW'(NUM_REQ - 1);
            rd_locked_q <= 1'b0;
            wr_locked_q <= 1'b0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_locked_q <= rd_locked_d;
            wr_locked_q <= wr_locked_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule
